sobel_result_writer: RTL
========================

SOBEL_RESULT_WRITER -- requirements
Module: sobel_result_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 256, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 256, rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 16, memory address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-004 SHALL have parameter MAG_W, default 11, width of incoming Sobel magnitude.
REQ-005 SHALL have parameter THRESH_EN, default 0; 1 selects binary edge output.
REQ-006 SHALL have parameter THRESHOLD, default 128, edge threshold compared against the saturated 8-bit value.
REQ-007 CLK  in  1  single clock; all logic on rising edge.
REQ-008 Reset  in  1  synchronous, active-low reset.
REQ-009 Start  in  1  begin one frame write; honored only in IDLE.
REQ-010 InValid  in  1  InMag holds a valid pixel.
REQ-011 InMag  in  MAG_W  unsigned Sobel magnitude.
REQ-012 InReady  out  1  writer accepts InMag this cycle.
REQ-013 MemWe  out  1  write request to result memory.
REQ-014 MemAddr  out  ADDR_W  write address.
REQ-015 MemData  out  8  write data.
REQ-016 MemAck  in  1  memory accepted current write.
REQ-017 Busy  out  1  high in WRITE state.
REQ-018 Done  out  1  one-cycle pulse after last write acknowledged.

Function
REQ-019 States SHALL be IDLE, WRITE, DONE; IDLE -> WRITE on Start; WRITE -> DONE when last pixel accepted and its write acknowledged; DONE -> IDLE unconditionally after one cycle.
REQ-020 On IDLE -> WRITE, column, row and address counters SHALL clear to 0.
REQ-021 Pixel accepted SHALL mean InValid & InReady on a rising edge.
REQ-022 InReady SHALL be 0 outside WRITE, 0 after last pixel accepted, else (!MemWe | MemAck).
REQ-023 Accepted pixel SHALL appear on MemWe/MemAddr/MemData the following cycle (latency 1).
REQ-024 MemWe, MemAddr, MemData SHALL be held stable while MemWe=1 and MemAck=0.
REQ-025 MemAck with simultaneous accept SHALL replace the output register with the new pixel, sustaining 1 pixel/cycle.
REQ-026 MemAck while MemWe=0 SHALL be ignored.
REQ-027 Data conversion: InMag > 255 SHALL saturate to 255, else InMag[7:0]; with THRESH_EN=1 MemData SHALL be 8'hFF when saturated value >= THRESHOLD, else 8'h00.
REQ-028 MemAddr SHALL equal row*IMG_W + col of the accepted pixel, produced by an incrementing address counter (no multiplier).
REQ-029 Column counter SHALL wrap IMG_W-1 -> 0 and increment row; row IMG_H-1 with col IMG_W-1 SHALL mark last pixel.
REQ-030 Start while Busy or in DONE SHALL be ignored.
REQ-031 Start and Done are not simultaneous; Start in the DONE cycle is ignored.

Reset
REQ-032 Reset=0 at a rising edge SHALL force IDLE, counters 0, MemWe=0, MemAddr=0, MemData=0, InReady=0, Busy=0, Done=0, overriding all other inputs.
REQ-033 Reset mid-frame SHALL abandon pending write without Done; next frame requires new Start.

Structure
REQ-034 State encoding and the saturation constant 8'hFF SHALL live in shared package sobel_pkg.
REQ-035 Column/row/address tracking SHALL be one sub-module, sobel_frame_counter, with clear, enable and last-pixel flag outputs.

Verification (IMG_W=4, IMG_H=2, ADDR_W=4)
REQ-036 Start, 8 pixels InMag=0..7, MemAck=1 -> MemAddr 0..7 consecutive cycles, MemData=InMag, one Done pulse 1 cycle after final write.
REQ-037 InMag=300, 255, 256 -> MemData 255, 255, 255; THRESH_EN=1, THRESHOLD=128, InMag=127/128 -> 8'h00/8'hFF.
REQ-038 MemAck=0 for 3 cycles on address 2 -> InReady=0, MemAddr=2 and MemData stable, resumes with address 3 after ack.
REQ-039 Start asserted in WRITE at pixel 3 -> ignored, addresses continue 4..7, single Done.
REQ-040 Reset=0 after 5 pixels -> next cycle all outputs 0, IDLE; new Start restarts at MemAddr 0.
REQ-041 Extra InValid after 8th accepted pixel -> InReady=0, no 9th write, counters not wrapped.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel result writer.
//   wr_state_e : writer FSM state encoding
//   SatMax     : saturated 8-bit magnitude, also the "edge" value in threshold mode
//   EdgeOff    : "no edge" value in threshold mode
package sobel_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDone  = 2'd2
  } wr_state_e;

  localparam logic [7:0] SatMax  = 8'hFF;
  localparam logic [7:0] EdgeOff = 8'h00;

endpackage

// File: rtl/sobel_frame_counter.sv
// Column/row/address tracker for one frame.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   clr_i  : restart at pixel (0,0), address 0
//   en_i   : advance to the next pixel
//   addr_o : linear address row*IMG_W + col of the current pixel
//   last_o : current pixel is the last one of the frame
// The address is a plain incrementing counter kept alongside col/row, so no
// multiplier is needed. Counting stops on the last pixel instead of wrapping.
module sobel_frame_counter #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_o = (col_q == ColMax) && (row_q == RowMax);
  assign addr_o = addr_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clr_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (en_i && !last_o) begin
      addr_d = addr_q + 1'b1;
      if (col_q == ColMax) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/sobel_result_writer.sv
// Writes one frame of Sobel magnitudes to a result memory.
//   clk_i        : clock, rising edge
//   rst_ni       : synchronous active-low reset
//   start_i      : begin a frame (only honoured while idle)
//   in_valid_i   : in_mag_i carries a pixel
//   in_mag_i     : unsigned Sobel magnitude
//   in_ready_o   : pixel is accepted this cycle when in_valid_i is also high
//   mem_we_o     : write request, held with addr/data until mem_ack_i
//   mem_addr_o   : write address
//   mem_data_o   : write data (saturated 8-bit or binary edge)
//   mem_ack_i    : memory took the current write
//   busy_o       : frame in progress
//   done_o       : one-cycle pulse after the last write is acknowledged
module sobel_result_writer
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W     = 256,
  parameter int unsigned IMG_H     = 256,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAG_W     = 11,
  parameter bit          THRESH_EN = 1'b0,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [MAG_W-1:0]  in_mag_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              done_o
);

  wr_state_e         state_q, state_d;
  logic              last_acc_q, last_acc_d;  // last pixel of the frame already taken
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  logic              accept;
  logic              start_frame;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic [7:0]        sat_mag;
  logic [7:0]        pix_data;

  // The output register may be refilled in the same cycle it is acknowledged.
  assign in_ready_o  = (state_q == StWrite) && !last_acc_q && (!we_q || mem_ack_i);
  assign accept      = in_valid_i && in_ready_o;
  assign start_frame = (state_q == StIdle) && start_i;

  always_comb begin
    sat_mag = (32'(in_mag_i) > 32'd255) ? SatMax : in_mag_i[7:0];
    if (THRESH_EN) begin
      pix_data = (32'(sat_mag) >= THRESHOLD) ? SatMax : EdgeOff;
    end else begin
      pix_data = sat_mag;
    end
  end

  sobel_frame_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_frame_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (start_frame),
    .en_i   (accept),
    .addr_o (cnt_addr),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    last_acc_d = last_acc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StWrite;
          last_acc_d = 1'b0;
        end
      end
      StWrite: begin
        // No pixel can follow the last one, so the pending write is the last write.
        if (last_acc_q && we_q && mem_ack_i) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      we_d   = 1'b1;
      addr_d = cnt_addr;
      data_d = pix_data;
      if (cnt_last) begin
        last_acc_d = 1'b1;
      end
    end else if (we_q && mem_ack_i) begin
      we_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      last_acc_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_acc_q <= last_acc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign busy_o     = (state_q == StWrite);
  assign done_o     = (state_q == StDone);

endmodule
